// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//
// Single-port word memory answering a simple CPU handshake on a shared,
// bidirectional data bus. A request (readM or writeM) is accepted in IDLE.
// The address, the operation and the write data are latched at acceptance.
// The block then answers with a one-cycle pulse:
//   - read : inputReady=1 and data driven with mem[latched address]
//   - write: memory updated on the edge entering RESP, ackOutput=1 in RESP
// A read and a write sampled together are served as a read. The write is
// dropped. Only address[ADDR_BITS-1:0] selects a word, so the upper address
// bits alias.
//
// Build option: define MEM_WAIT_STATES_EN to insert a WAIT state of LATENCY
// cycles between acceptance and response, so the total latency is LATENCY+1.
// Without it, IDLE goes straight to RESP and the response comes in the cycle
// after acceptance. In that build, LATENCY is ignored.
//
// Ports
//   clk         in     rising-edge clock
//   reset_n     in     asynchronous active-low reset (memory keeps its contents)
//   readM       in     read request, held until inputReady
//   writeM      in     write request, held until ackOutput
//   address     in     word address, WORD_SIZE bits, low ADDR_BITS used
//   data        inout  write data in / read data out, high-Z unless responding
//   inputReady  out    one-cycle read-data-valid pulse
//   ackOutput   out    one-cycle write-committed pulse
// -----------------------------------------------------------------------------
module memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t               r_state;
  logic                 r_input_ready;
  logic                 r_ack_output;
  logic                 r_drive;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_enter_resp;
  logic                 w_is_write;
  logic                 w_mem_we;
  logic                 w_mem_re;
  logic [ADDR_BITS-1:0] w_mem_addr;
  logic [WORD_SIZE-1:0] w_mem_wdata;
  logic                 w_unused_addr;

  // Nothing is accepted while reset is asserted. The memory array has no
  // reset, so without this gate, a request held during reset could still
  // write a word.
  assign w_accept = reset_n && (r_state == IDLE) && (readM || writeM);

`ifdef MEM_WAIT_STATES_EN
  logic [3:0]           r_count;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_is_write;
  logic [WORD_SIZE-1:0] r_wdata;

  // The response is committed on the edge that ends the last WAIT cycle.
  // The operands come from the copies latched at acceptance, so any bus
  // activity during WAIT is ignored.
  assign w_enter_resp = (r_state == WAIT) && (r_count == 4'd0);
  assign w_is_write   = r_is_write;
  assign w_mem_addr   = r_addr;
  assign w_mem_wdata  = r_wdata;
`else
  // The acceptance edge is also the edge entering RESP, so the operands come
  // straight off the bus. A simultaneous read and write counts as a read.
  assign w_enter_resp = w_accept;
  assign w_is_write   = !readM;
  assign w_mem_addr   = address[ADDR_BITS-1:0];
  assign w_mem_wdata  = data;
`endif

  assign w_mem_we = w_enter_resp && w_is_write;
  assign w_mem_re = w_enter_resp && !w_is_write;

  // The upper address bits are deliberately unused (they alias).
  assign w_unused_addr = &{1'b0, address};

  // NOTE: Memory has no reset. Contents must survive reset_n, and a resettable
  // array could not map onto RAM macros.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
    if (w_mem_re) begin
      r_rdata <= r_mem[w_mem_addr];
    end
  end

  // Control FSM. The response flags are registered. They are true only in
  // the single RESP cycle because they are loaded from the one-cycle
  // enter-RESP strobe.
  // NOTE: State registers use non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_input_ready <= 1'b0;
      r_ack_output  <= 1'b0;
      r_drive       <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
      r_count       <= 4'd0;
      r_addr        <= '0;
      r_is_write    <= 1'b0;
      r_wdata       <= '0;
`endif
    end else begin
      r_input_ready <= w_mem_re;
      r_ack_output  <= w_mem_we;
      r_drive       <= w_mem_re;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
`ifdef MEM_WAIT_STATES_EN
            r_state    <= WAIT;
            r_count    <= 4'(LATENCY - 1);
            r_addr     <= address[ADDR_BITS-1:0];
            r_is_write <= !readM;
            r_wdata    <= data;
`else
            r_state    <= RESP;
`endif
          end
        end
`ifdef MEM_WAIT_STATES_EN
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
`endif
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inputReady = r_input_ready;
  assign ackOutput  = r_ack_output;
  assign data       = r_drive ? r_rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_responder
//
// Directed bench for memory_responder. A table of single transactions carries
// hand-computed responses. Hand-written sequences cover reset, back-to-back
// reads and abort-by-reset.
//
// The bench parks the data bus at 0 through its own driver whenever it is not
// expecting read data. Any cycle in which the DUT should be high-Z must
// therefore read back 0.
// -----------------------------------------------------------------------------
module tb_memory_responder;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 3;
`ifdef MEM_WAIT_STATES_EN
  localparam int WAITS = LATENCY;
`else
  localparam int WAITS = 0;
`endif

  typedef enum logic [1:0] { OP_RD, OP_WR, OP_BOTH } op_t;

  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_ready;
    logic        exp_ack;
    logic [15:0] exp_data;
  } vec_t;

  localparam int N_VEC = 14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  logic        tb_en;
  logic [15:0] tb_data;
  wire  [15:0] data;
  logic        inputReady;
  logic        ackOutput;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [N_VEC];

  assign data = tb_en ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  memory_responder #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .ackOutput  (ackOutput)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One complete transaction. The request is raised, then accepted on the
  // next edge. The WAIT cycles are checked for silence, then the response
  // cycle, then the idle cycle after it.
  task automatic run_txn(input vec_t v, input int idx);
    @(posedge clk); #1;
    readM   = (v.op != OP_WR);
    writeM  = (v.op != OP_RD);
    address = v.addr;
    tb_en   = 1'b1;
    tb_data = v.wdata;
    @(posedge clk); #1;
    // Scramble the bus after acceptance; the DUT must use its latched copy.
    address = ~v.addr;
    tb_data = 16'h0000;
    if (v.op != OP_WR) tb_en = 1'b0;
    for (int w = 0; w < WAITS; w++) begin
      @(negedge clk);
      check($sformatf("v%0d_wait%0d_ready", idx, w), {31'd0, inputReady}, 32'd0);
      check($sformatf("v%0d_wait%0d_ack", idx, w), {31'd0, ackOutput}, 32'd0);
      if (v.op == OP_WR) check($sformatf("v%0d_wait%0d_bus", idx, w), {16'd0, data}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("v%0d_resp_ready", idx), {31'd0, inputReady}, {31'd0, v.exp_ready});
    check($sformatf("v%0d_resp_ack", idx), {31'd0, ackOutput}, {31'd0, v.exp_ack});
    check($sformatf("v%0d_resp_data", idx), {16'd0, data},
          v.exp_ready ? {16'd0, v.exp_data} : 32'd0);
    @(posedge clk); #1;
    readM   = 1'b0;
    writeM  = 1'b0;
    tb_en   = 1'b1;
    tb_data = 16'h0000;
    @(negedge clk);
    check($sformatf("v%0d_post_ready", idx), {31'd0, inputReady}, 32'd0);
    check($sformatf("v%0d_post_ack", idx), {31'd0, ackOutput}, 32'd0);
    check($sformatf("v%0d_post_bus", idx), {16'd0, data}, 32'd0);
  endtask

  initial begin
    int   p1;
    int   p2;
    logic pulse;
    vec_t rv;

    reset_n = 1'b0;
    readM   = 1'b0;
    writeM  = 1'b0;
    address = 16'h0000;
    tb_en   = 1'b1;
    tb_data = 16'h0000;

    //                op       addr      wdata     rdy   ack   rdata
    vecs[0]  = '{OP_WR,   16'h0012, 16'hBEEF, 1'b0, 1'b1, 16'h0000};
    vecs[1]  = '{OP_RD,   16'h0012, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vecs[2]  = '{OP_WR,   16'h0107, 16'hA5A5, 1'b0, 1'b1, 16'h0000};
    vecs[3]  = '{OP_RD,   16'h0007, 16'h0000, 1'b1, 1'b0, 16'hA5A5};
    vecs[4]  = '{OP_WR,   16'h0005, 16'h0F0F, 1'b0, 1'b1, 16'h0000};
    vecs[5]  = '{OP_BOTH, 16'h0005, 16'h1234, 1'b1, 1'b0, 16'h0F0F};
    vecs[6]  = '{OP_RD,   16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0F0F};
    vecs[7]  = '{OP_WR,   16'h0003, 16'h1111, 1'b0, 1'b1, 16'h0000};
    vecs[8]  = '{OP_WR,   16'h00FF, 16'h8001, 1'b0, 1'b1, 16'h0000};
    vecs[9]  = '{OP_RD,   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h8001};
    vecs[10] = '{OP_WR,   16'h0100, 16'h7E57, 1'b0, 1'b1, 16'h0000};
    vecs[11] = '{OP_RD,   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h7E57};
    vecs[12] = '{OP_RD,   16'h0003, 16'h0000, 1'b1, 1'b0, 16'h1111};
    vecs[13] = '{OP_RD,   16'h0107, 16'h0000, 1'b1, 1'b0, 16'hA5A5};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, inputReady}, 32'd0);
    check("reset_ack", {31'd0, ackOutput}, 32'd0);
    check("reset_bus", {16'd0, data}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      run_txn(vecs[i], i);
    end

    // Back-to-back reads: readM held high. Each response is followed by an
    // IDLE cycle that re-accepts, so the pulses are WAITS+2 cycles apart.
    // There are WAITS+1 quiet cycles between them.
    p1 = WAITS + 1;
    p2 = p1 + WAITS + 2;
    @(posedge clk); #1;
    readM   = 1'b1;
    address = 16'h0012;
    for (int c = 0; c <= p2 + 1; c++) begin
      @(negedge clk);
      pulse = (c == p1) || (c == p2);
      check($sformatf("b2b_c%0d_ready", c), {31'd0, inputReady}, {31'd0, pulse});
      check($sformatf("b2b_c%0d_ack", c), {31'd0, ackOutput}, 32'd0);
      check($sformatf("b2b_c%0d_bus", c), {16'd0, data}, pulse ? 32'h0000BEEF : 32'd0);
      if ((c + 1 == p1) || (c + 1 == p2)) tb_en = 1'b0;
      @(posedge clk); #1;
      if (c == p2) readM = 1'b0;
      if ((c == p1) || (c == p2)) tb_en = 1'b1;
    end

    // Reset asserted in the middle of a read response releases everything at
    // once. Memory contents survive.
    @(posedge clk); #1;
    readM   = 1'b1;
    address = 16'h0007;
    @(posedge clk); #1;
    tb_en = 1'b0;
    repeat (WAITS) @(posedge clk);
    @(negedge clk);
    check("rstresp_pre_ready", {31'd0, inputReady}, 32'd1);
    #1;
    reset_n = 1'b0;
    tb_en   = 1'b1;
    tb_data = 16'h0000;
    readM   = 1'b0;
    #1;
    check("rstresp_ready", {31'd0, inputReady}, 32'd0);
    check("rstresp_ack", {31'd0, ackOutput}, 32'd0);
    check("rstresp_bus", {16'd0, data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rv = '{OP_RD, 16'h0007, 16'h0000, 1'b1, 1'b0, 16'hA5A5};
    run_txn(rv, 100);

    // A write aborted by reset: in WAIT when wait states are built in,
    // otherwise before acceptance. mem[3] must keep 0x1111.
    @(posedge clk); #1;
    writeM  = 1'b1;
    address = 16'h0003;
    tb_data = 16'h5555;
`ifdef MEM_WAIT_STATES_EN
    @(posedge clk); #1;
    tb_data = 16'h0000;
`endif
    @(negedge clk);
    reset_n = 1'b0;
    tb_data = 16'h0000;
    #1;
    check("abort_ready", {31'd0, inputReady}, 32'd0);
    check("abort_ack", {31'd0, ackOutput}, 32'd0);
    check("abort_bus", {16'd0, data}, 32'd0);
    writeM = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv = '{OP_RD, 16'h0003, 16'h0000, 1'b1, 1'b0, 16'h1111};
    run_txn(rv, 101);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
